// File: rtl/spi_master_gen.sv
// SPI master for the FPGA-MCU link: all four CPOL/CPHA modes, programmable SCLK
// divider, MSB/LSB-first shifting and bursts of up to 256 words under one chip-select.
module spi_master_gen #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [7:0]        burst_len,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              done,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              spi_cs_n
);

  localparam int unsigned BIT_W = $clog2(DATA_W);
  localparam int unsigned WRD_W = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_XFER, S_WAIT_TX, S_HOLD, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              lsb_q, lsb_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [WRD_W-1:0]  word_cnt_q, word_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              phase_q, phase_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic              tx_ready_d, rx_valid_d, busy_d, done_d;
  logic              sclk_d, mosi_d, cs_n_d;
  logic [DATA_W-1:0] rx_data_d;

  logic              active_c, tick_c, lead_tick_c, trail_tick_c, sample_c;
  logic              last_bit_c, word_end_c, more_c, accept_c, load_next_c;
  logic [DATA_W-1:0] tx_shifted_c;

  // Bit currently presented at the serial output end of a word
  function automatic logic out_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  assign active_c     = (state_q == S_SETUP) || (state_q == S_XFER) || (state_q == S_HOLD);
  assign tick_c       = active_c && (div_cnt_q == div_q);
  assign lead_tick_c  = (state_q == S_XFER) && tick_c && !phase_q;
  assign trail_tick_c = (state_q == S_XFER) && tick_c && phase_q;
  assign sample_c     = cpha_q ? trail_tick_c : lead_tick_c;
  assign last_bit_c   = (bit_cnt_q == BIT_W'(DATA_W - 1));
  assign word_end_c   = trail_tick_c && last_bit_c;
  assign more_c       = (word_cnt_q != '0);
  assign accept_c     = (state_q == S_IDLE) && start && tx_valid;
  assign load_next_c  = ((state_q == S_WAIT_TX) && tx_valid) || (word_end_c && more_c && tx_valid);
  assign tx_shifted_c = lsb_q ? {1'b0, tx_sh_q[DATA_W-1:1]} : {tx_sh_q[DATA_W-2:0], 1'b0};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept_c) state_d = S_SETUP;
      S_SETUP:   if (tick_c) state_d = S_XFER;
      S_XFER:    if (word_end_c) state_d = !more_c ? S_HOLD : (tx_valid ? S_XFER : S_WAIT_TX);
      S_WAIT_TX: if (tx_valid) state_d = S_SETUP;
      S_HOLD:    if (tick_c) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    div_d      = div_q;
    word_cnt_d = word_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    phase_d    = phase_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data;
    sclk_d     = spi_sclk;
    mosi_d     = spi_mosi;
    cs_n_d     = spi_cs_n;
    tx_ready_d = 1'b0;
    rx_valid_d = 1'b0;
    done_d     = 1'b0;
    busy_d     = (state_d != S_IDLE);
    div_cnt_d  = (active_c && !tick_c) ? div_cnt_q + DIV_W'(1) : '0;

    if (accept_c) begin
      cpol_d     = cpol;
      cpha_d     = cpha;
      lsb_d      = lsb_first;
      div_d      = clk_div;
      word_cnt_d = burst_len;
      bit_cnt_d  = '0;
      phase_d    = 1'b0;
      tx_sh_d    = tx_data;
      tx_ready_d = 1'b1;
      sclk_d     = cpol;
      cs_n_d     = 1'b0;
      if (!cpha) mosi_d = out_bit(tx_data, lsb_first);
    end

    if (lead_tick_c) begin
      sclk_d  = ~spi_sclk;
      phase_d = 1'b1;
      if (cpha_q) mosi_d = out_bit(tx_sh_q, lsb_q);
    end

    if (trail_tick_c) begin
      sclk_d    = ~spi_sclk;
      phase_d   = 1'b0;
      tx_sh_d   = tx_shifted_c;
      bit_cnt_d = bit_cnt_q + BIT_W'(1);
      if (!cpha_q && !last_bit_c) mosi_d = out_bit(tx_shifted_c, lsb_q);
    end

    // Capture MISO; the word is published on the cycle after its final sample
    if (sample_c) begin
      rx_sh_d = lsb_q ? {spi_miso, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], spi_miso};
      if (last_bit_c) begin
        rx_data_d  = rx_sh_d;
        rx_valid_d = 1'b1;
      end
    end

    if (load_next_c) begin
      tx_sh_d    = tx_data;
      tx_ready_d = 1'b1;
      bit_cnt_d  = '0;
      phase_d    = 1'b0;
      word_cnt_d = word_cnt_q - WRD_W'(1);
      if (!cpha_q) mosi_d = out_bit(tx_data, lsb_q);
    end

    if ((state_q == S_HOLD) && tick_c) begin
      cs_n_d = 1'b1;
      done_d = 1'b1;
      mosi_d = 1'b1;
    end
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      div_q      <= '0;
      div_cnt_q  <= '0;
      word_cnt_q <= '0;
      bit_cnt_q  <= '0;
      phase_q    <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data    <= '0;
      tx_ready   <= 1'b0;
      rx_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      spi_sclk   <= 1'b0;
      spi_mosi   <= 1'b1;
      spi_cs_n   <= 1'b1;
    end else begin
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
      div_q      <= div_d;
      div_cnt_q  <= div_cnt_d;
      word_cnt_q <= word_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      phase_q    <= phase_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data    <= rx_data_d;
      tx_ready   <= tx_ready_d;
      rx_valid   <= rx_valid_d;
      busy       <= busy_d;
      done       <= done_d;
      spi_sclk   <= sclk_d;
      spi_mosi   <= mosi_d;
      spi_cs_n   <= cs_n_d;
    end
  end

endmodule

// File: tb/tb_spi_master_gen.sv
// Directed bench for spi_master_gen: loopback and slave-model transfers in all
// modes, LSB-first, multi-word bursts, TX underrun gap and mid-burst reset.
module tb_spi_master_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic [7:0] clk_div = 8'd1, burst_len = 8'd0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, rx_valid, busy, done;
  logic [7:0] rx_data;
  logic       spi_sclk, spi_mosi, spi_miso, spi_cs_n;

  spi_master_gen #(.DATA_W(8), .DIV_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .clk_div(clk_div), .burst_len(burst_len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model: shifts out s_tx in the configured mode and records MOSI
  logic       t_cpol = 1'b0, t_cpha = 1'b0, t_lsb = 1'b0, loop_en = 1'b1;
  logic [7:0] s_tx = 8'h00, s_rx = 8'h00;
  logic       s_miso = 1'b1, s_first = 1'b0, s_lead = 1'b0;
  logic       s_pcs = 1'b1, s_psclk = 1'b0;
  int         s_idx = 0, s_nbits = 0;

  assign spi_miso = loop_en ? spi_mosi : s_miso;

  function automatic logic s_bit(input int i);
    logic [2:0] k;
    k = 3'(i);
    return t_lsb ? s_tx[k] : s_tx[3'd7 - k];
  endfunction

  always @(spi_sclk or spi_cs_n) begin
    if (spi_cs_n !== s_pcs && spi_cs_n === 1'b0) begin
      s_idx = 0; s_nbits = 0; s_rx = 8'h00; s_lead = 1'b0;
      if (!t_cpha) s_miso = s_bit(0);
    end else if (spi_sclk !== s_psclk && spi_cs_n === 1'b0) begin
      if (spi_sclk !== t_cpol) begin
        s_lead = 1'b1;
        if (!t_cpha) begin
          if (s_nbits == 0) s_first = spi_mosi;
          s_rx = {s_rx[6:0], spi_mosi}; s_nbits++;
        end else s_miso = s_bit(s_idx);
      end else if (s_lead) begin
        if (!t_cpha) begin
          s_idx++; s_miso = s_bit(s_idx);
        end else begin
          if (s_nbits == 0) s_first = spi_mosi;
          s_rx = {s_rx[6:0], spi_mosi}; s_nbits++; s_idx++;
        end
      end
    end
    s_pcs = spi_cs_n;
    s_psclk = spi_sclk;
  end

  logic [7:0] words [8];
  logic [7:0] rx_hist [8];
  int n_lead, n_txr, n_rxv, n_done, n_csl, per_bad, gap_bad, gap_seen;
  logic busy_seen;

  task automatic run_burst(input logic cp, input logic ch, input logic lsb, input logic [7:0] div,
                           input logic [7:0] blen, input logic loop, input logic gap, input logic abort);
    int cyc, last_lead, gap_cnt, idx;
    logic prev;
    n_lead = 0; n_txr = 0; n_rxv = 0; n_done = 0; n_csl = 0;
    per_bad = 0; gap_bad = 0; gap_seen = 0; busy_seen = 1'b0;
    t_cpol = cp; t_cpha = ch; t_lsb = lsb; loop_en = loop;
    @(negedge clk);
    cpol = cp; cpha = ch; lsb_first = lsb; clk_div = div; burst_len = blen;
    tx_data = words[0]; tx_valid = 1'b1; start = 1'b1;
    prev = spi_sclk; idx = 0; gap_cnt = 0; cyc = 0; last_lead = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 1) busy_seen = busy;
      if (tx_ready) begin
        n_txr++;
        if (idx < 7) idx++;
        tx_data = words[idx];
        if (gap && idx == 1) tx_valid = 1'b0;
      end
      if (rx_valid) begin
        if (n_rxv < 8) rx_hist[n_rxv] = rx_data;
        n_rxv++;
        if (gap && n_rxv == 1) gap_cnt = 20;
      end
      if (gap_cnt > 0) begin
        if (gap_cnt <= 16) begin
          gap_seen++;
          if (spi_sclk !== cp || spi_cs_n !== 1'b0) gap_bad++;
        end
        gap_cnt--;
        if (gap_cnt == 0) tx_valid = 1'b1;
      end
      if (spi_cs_n === 1'b0) n_csl++;
      if (spi_sclk !== prev && spi_sclk !== cp) begin
        n_lead++;
        if (n_lead > 1 && (cyc - last_lead) != 2 * (int'(div) + 1)) per_bad++;
        last_lead = cyc;
      end
      prev = spi_sclk;
      if (abort && n_lead == 5) begin
        rst_n = 1'b0;
        #1;
        check("abort_cs_n", spi_cs_n, 1);
        check("abort_sclk", spi_sclk, 0);
        check("abort_busy", busy, 0);
        check("abort_rx_data", rx_data, 0);
        repeat (4) begin
          @(negedge clk);
          if (done || rx_valid) n_done++;
        end
        check("abort_no_pulses", n_done, 0);
        rst_n = 1'b1;
        break;
      end
      if (done) begin
        n_done++;
        break;
      end
      if (cyc > 8000) begin
        check("timeout", 1, 0);
        break;
      end
    end
    tx_valid = 1'b0;
  endtask

  logic [7:0] slave_words [4];
  initial begin
    slave_words[0] = 8'hC3; slave_words[1] = 8'hC3;
    slave_words[2] = 8'hC3; slave_words[3] = 8'hC3;
    for (int i = 0; i < 8; i++) words[i] = 8'h00;

    #23;
    check("rst_sclk", spi_sclk, 0);
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_mosi", spi_mosi, 1);
    check("rst_pulses", {tx_ready, rx_valid, busy, done}, 4'b0000);
    check("rst_rx_data", rx_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Mode 0 loopback of 0xA5
    words[0] = 8'hA5;
    run_burst(1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 1'b1, 1'b0, 1'b0);
    check("m0_busy", busy_seen, 1);
    check("m0_sclk_pulses", n_lead, 8);
    check("m0_period", per_bad, 0);
    check("m0_mosi_bits", s_rx, 8'hA5);
    check("m0_rx_data", rx_data, 8'hA5);
    check("m0_rx_valid", n_rxv, 1);
    check("m0_tx_ready", n_txr, 1);
    check("m0_done", n_done, 1);
    check("m0_cs_low", n_csl, 36);
    @(negedge clk);
    check("m0_idle", {busy, spi_cs_n, spi_mosi}, 3'b011);

    // Four modes against the slave model
    for (int m = 0; m < 4; m++) begin
      logic cp, ch;
      cp = m[1]; ch = m[0];
      words[0] = 8'h3C; s_tx = slave_words[m];
      run_burst(cp, ch, 1'b0, 8'd2, 8'd0, 1'b0, 1'b0, 1'b0);
      check($sformatf("mode%0d_rx", m), rx_data, 8'hC3);
      check($sformatf("mode%0d_slave_rx", m), s_rx, 8'h3C);
      check($sformatf("mode%0d_pulses", m), n_lead, 8);
      @(negedge clk);
      check($sformatf("mode%0d_idle_sclk", m), spi_sclk, cp);
    end

    // LSB-first loopback
    words[0] = 8'h01;
    run_burst(1'b0, 1'b0, 1'b1, 8'd1, 8'd0, 1'b1, 1'b0, 1'b0);
    check("lsb_first_bit", s_first, 1);
    check("lsb_rx", rx_data, 8'h01);

    // Four-word contiguous burst
    for (int i = 0; i < 4; i++) words[i] = 8'(i);
    words[4] = 8'hEE;
    run_burst(1'b0, 1'b0, 1'b0, 8'd1, 8'd3, 1'b1, 1'b0, 1'b0);
    check("burst_sclk_pulses", n_lead, 32);
    check("burst_contiguous", per_bad, 0);
    check("burst_tx_ready", n_txr, 4);
    check("burst_rx_valid", n_rxv, 4);
    check("burst_done", n_done, 1);
    check("burst_cs_low", n_csl, 132);
    for (int i = 0; i < 4; i++) check($sformatf("burst_rx%0d", i), rx_hist[i], 32'(i));

    // TX underrun gap between two words
    words[0] = 8'h5A; words[1] = 8'h96; words[2] = 8'hEE;
    run_burst(1'b0, 1'b0, 1'b0, 8'd1, 8'd1, 1'b1, 1'b1, 1'b0);
    check("gap_seen", gap_seen, 16);
    check("gap_bus_idle", gap_bad, 0);
    check("gap_rx_valid", n_rxv, 2);
    check("gap_rx0", rx_hist[0], 8'h5A);
    check("gap_rx1", rx_hist[1], 8'h96);
    check("gap_tx_ready", n_txr, 2);
    check("gap_done", n_done, 1);

    // Reset mid-word, then a normal burst
    words[0] = 8'hF0;
    run_burst(1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    words[0] = 8'h69;
    run_burst(1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 1'b1, 1'b0, 1'b0);
    check("post_rst_rx", rx_data, 8'h69);
    check("post_rst_done", n_done, 1);
    check("post_rst_pulses", n_lead, 8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_master_gen.md
Name: spi_master_gen

Overview:
- Parametrised SPI master for the FPGA–MCU link. Supports all four CPOL/CPHA modes, a programmable SCLK divider, a configurable word width, MSB- or LSB-first shifting and bursts of 1..256 words under a single chip-select.
- Word data moves through valid/ready streams, so a FIFO or test-pattern generator can feed TX and consume RX.

Parameters:
- DATA_W, 8, bits per SPI word (4..32).
- DIV_W, 8, width of clk_div.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request; accepted only in IDLE
- cpol  in  1  SCLK idle level; sampled at start
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; sampled at start
- lsb_first  in  1  bit order; sampled at start
- clk_div  in  DIV_W  SCLK half-period = clk_div+1 clk cycles; sampled at start
- burst_len  in  8  words per burst = burst_len+1; sampled at start
- tx_data  in  DATA_W  next word to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  one-cycle pulse when a tx word is consumed
- rx_data  out  DATA_W  last received word; held until the next word completes
- rx_valid  out  1  one-cycle pulse per received word
- busy  out  1  high from the cycle after start accept through DONE
- done  out  1  one-cycle pulse at burst end
- spi_sclk  out  1  serial clock
- spi_mosi  out  1  serial data out
- spi_miso  in  1  serial data in
- spi_cs_n  out  1  chip select, active-low

Behaviour:
- Reset values: spi_sclk=0, spi_cs_n=1, spi_mosi=1, tx_ready=0, rx_valid=0, rx_data=0, busy=0, done=0, state IDLE.
- Asserting rst_n low mid-burst aborts the burst immediately. No done and no rx_valid are issued.
- Latched configuration (cpol, cpha, lsb_first, clk_div, burst_len) is held constant for the whole burst. Input changes during a burst have no effect.
- After the first start, spi_sclk idles at the latched cpol.
- A divider counter produces a tick every clk_div+1 cycles while the state is not IDLE, WAIT_TX or DONE.
- States:
  - IDLE: when start && tx_valid, latch config, load tx_data into the shift register and pulse tx_ready. Next state is SETUP. If start arrives without tx_valid, start is ignored.
  - SETUP: cs_n=0. If cpha=0, mosi = first bit. Lasts one half-period, then XFER.
  - XFER: each bit has two ticks, leading edge then trailing edge, and sclk toggles on each.
    - cpha=0: sample miso on the leading edge; shift and drive the next mosi bit on the trailing edge.
    - cpha=1: drive mosi on the leading edge; sample on the trailing edge.
    - A bit counter counts 0..DATA_W-1. After the final sample tick, rx_data is updated and rx_valid pulses on the next cycle.
    - At the word's last trailing edge: if words remain and tx_valid=1, load the next word, pulse tx_ready and continue with no gap. If tx_valid=0, go to WAIT_TX. If no words remain, go to HOLD.
  - WAIT_TX: sclk at cpol, cs_n stays 0, divider frozen. When tx_valid is seen, load the word, pulse tx_ready and go to SETUP. Bus timing then restarts exactly as for the first word.
  - HOLD: cs_n=0 for one half-period, then cs_n=1 and go to DONE.
  - DONE: pulse done for 1 cycle, mosi=1, then IDLE.
- Bit order:
  - lsb_first=0: transmit shifts out bit DATA_W-1 first; received bits shift in at bit 0.
  - lsb_first=1: the mirror of the above.
- The word counter is 8-bit and counts down from burst_len. burst_len=255 gives 256 words with no wrap.
- start while busy is ignored.
- tx_ready pulses exactly burst_len+1 times per burst. rx_valid pulses exactly burst_len+1 times per burst.

Test Plan:
- Mode 0, DATA_W=8, clk_div=1, burst_len=0, tx=0xA5, miso looped to mosi:
  - 8 sclk pulses, each 4 clk per period; mosi bits 1,0,1,0,0,1,0,1.
  - rx_data=0xA5 with one rx_valid pulse; one done pulse; cs_n low for 2+32+2 clk.
- All four modes, tx=0x3C, slave model shifts out 0xC3: rx_data=0xC3 in each mode. Sclk idles at cpol; sampling edge matches cpha.
- lsb_first=1, tx=0x01: first mosi bit is 1; loopback rx_data=0x01.
- burst_len=3, tx words 0x00..0x03 always valid:
  - 32 contiguous sclk pulses under one cs_n low; 4 tx_ready pulses, 4 rx_valid pulses, 1 done pulse.
- burst_len=1, tx_valid dropped for 20 clk after word 0: sclk held at cpol and cs_n stays low during the gap; second word completes correctly.
- rst_n asserted at bit 4 of a word: cs_n=1, sclk=0, busy=0 immediately. A following start runs a normal burst.
